// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage of the DLX datapath: owns the PC and computes the next PC.
// It issues req/ack fetches to instruction memory and holds each instruction under valid/ready.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        arst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  input  logic        ex_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jmp,
  input  logic [25:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_target
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } fetchState_e;

  fetchState_e state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] pcPlus4;
  logic [31:0] brTarget;
  logic [31:0] nextPc;
  logic        accept;

  assign pcPlus4  = pc_q + 32'd4;
  assign brTarget = pcPlus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign accept   = (state_q == VALID) && ex_ready;

  // Redirect priority is jr > jmp > branch > sequential.
  always_comb begin
    nextPc = pcPlus4;
    if (jr) begin
      nextPc = jr_target & 32'hFFFF_FFFC;
    end else if (jmp) begin
      nextPc = {pcPlus4[31:28], jmp_target, 2'b00};
    end else if (br_taken) begin
      nextPc = brTarget;
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = VALID;
        end
      end
      VALID: begin
        if (accept) begin
          pc_d    = nextPc;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req    = (state_q == FETCH);
    imem_addr   = pc_q;
    instr_valid = (state_q == VALID);
    instr       = instr_q;
    pc          = pc_q;
    pc_plus4    = pcPlus4;
  end

endmodule
